// File: rtl/cmd_fetch_unit.sv
// cmd_fetch_unit: reads the context IP, fetches the command at that IP,
// writes IP+1 back under the bus lock, then offers the command downstream.
module cmd_fetch_unit #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REG_IP_OFS = 0,
    parameter int TMO        = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              disp_online,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              read_q,
    output logic              write_q,
    input  logic              read_dn,
    input  logic              write_dn,
    output logic              halt_q,
    output logic [DATA_W-1:0] cmd,
    output logic [ADDR_W-1:0] cmd_ptr,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              busy,
    output logic              err
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_RD_IP_REQ   = 3'd1;
    localparam logic [2:0] S_RD_IP_WAIT  = 3'd2;
    localparam logic [2:0] S_RD_CMD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_CMD_WAIT = 3'd4;
    localparam logic [2:0] S_WR_IP_REQ   = 3'd5;
    localparam logic [2:0] S_WR_IP_WAIT  = 3'd6;
    localparam logic [2:0] S_PRESENT     = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        tmr_q, tmr_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] cmd_q, cmd_d;
    logic [ADDR_W-1:0] cmd_ptr_q, cmd_ptr_d;
    logic              read_d, write_d, halt_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] ip_addr;
    logic              is_wait;
    logic              dn;
    logic              armed;
    logic              accept;

    assign ip_addr = base_q + ADDR_W'(REG_IP_OFS);
    assign is_wait = (state_q == S_RD_IP_WAIT) || (state_q == S_RD_CMD_WAIT)
                  || (state_q == S_WR_IP_WAIT);
    assign dn      = (state_q == S_WR_IP_WAIT) ? write_dn : read_dn;
    // The cycle carrying the request pulse never accepts a completion.
    assign armed   = is_wait && !read_q && !write_q;
    assign accept  = armed && dn;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        ptr_d       = ptr_q;
        tmr_d       = tmr_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        cmd_d       = cmd_q;
        cmd_ptr_d   = cmd_ptr_q;
        read_d      = 1'b0;
        write_d     = 1'b0;
        halt_d      = halt_q;
        cmd_valid_d = cmd_valid_q;
        err_d       = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    err_d   = 1'b0;
                    halt_d  = 1'b1;
                    state_d = S_RD_IP_REQ;
                end
            end
            S_RD_IP_REQ: begin
                if (disp_online) begin
                    bus_addr_d = ip_addr;
                    read_d     = 1'b1;
                    tmr_d      = 8'(TMO);
                    state_d    = S_RD_IP_WAIT;
                end
            end
            S_RD_IP_WAIT: begin
                if (accept) begin
                    ptr_d   = bus_rdata[ADDR_W-1:0];
                    state_d = S_RD_CMD_REQ;
                end
            end
            S_RD_CMD_REQ: begin
                if (disp_online) begin
                    bus_addr_d = ptr_q;
                    read_d     = 1'b1;
                    tmr_d      = 8'(TMO);
                    state_d    = S_RD_CMD_WAIT;
                end
            end
            S_RD_CMD_WAIT: begin
                if (accept) begin
                    cmd_d     = bus_rdata;
                    cmd_ptr_d = ptr_q;
                    state_d   = S_WR_IP_REQ;
                end
            end
            S_WR_IP_REQ: begin
                if (disp_online) begin
                    bus_addr_d                  = ip_addr;
                    bus_wdata_d                 = '0;
                    bus_wdata_d[ADDR_W-1:0]     = ptr_q + ADDR_W'(1);
                    write_d                     = 1'b1;
                    tmr_d                       = 8'(TMO);
                    state_d                     = S_WR_IP_WAIT;
                end
            end
            S_WR_IP_WAIT: begin
                if (accept) begin
                    halt_d      = 1'b0;
                    cmd_valid_d = 1'b1;
                    state_d     = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (armed && !dn) begin
            if (tmr_q <= 8'd1) begin
                tmr_d   = 8'd0;
                err_d   = 1'b1;
                halt_d  = 1'b0;
                state_d = S_IDLE;
            end else begin
                tmr_d = tmr_q - 8'd1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            ptr_q       <= '0;
            tmr_q       <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            cmd_q       <= '0;
            cmd_ptr_q   <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            halt_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            ptr_q       <= ptr_d;
            tmr_q       <= tmr_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            cmd_q       <= cmd_d;
            cmd_ptr_q   <= cmd_ptr_d;
            read_q      <= read_d;
            write_q     <= write_d;
            halt_q      <= halt_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign cmd       = cmd_q;
    assign cmd_ptr   = cmd_ptr_q;
    assign cmd_valid = cmd_valid_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
